// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Turns a CPU store of byte (SB), halfword (SH) or word (SW) width into
// whole-word accesses to the data cache. Sub-word stores do a read of the
// containing word, merge the new bytes into it, and write the word back.
// Word stores skip the read. Unsupported width codes finish without
// touching memory.
//
// Optional feature: define MISALIGN_TRAP_EN to compile in misalignment
// trapping (SH with addr[0]=1, SW with addr[1:0]!=00). A trapped store goes
// straight to DONE with misalign_err raised for that cycle. Without the macro,
// misalign_err is tied low and the low address bits are ignored for SH/SW.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   st_req        store request, sampled only in IDLE
//   func[2:0]     store width: 000 SB, 001 SH, 010 SW, others unsupported
//   addr[31:0]    byte address of the store
//   wdata[31:0]   store data (low byte / low halfword for SB / SH)
//   busy          CPU stall request
//   done          one-cycle completion pulse
//   mem_read      word read strobe to the data cache
//   mem_write     word write strobe to the data cache
//   mem_addr      word-aligned cache address
//   mem_wdata     merged write word
//   mem_rdata     read word from the cache
//   mem_busy      cache wait; access accepted in the cycle it is low
//   misalign_err  misaligned-store flag
// -----------------------------------------------------------------------------
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_req,
    input  logic [2:0]  func,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic        misalign_err
);

    localparam logic [2:0] FUNC_SB = 3'b000;
    localparam logic [2:0] FUNC_SH = 3'b001;
    localparam logic [2:0] FUNC_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  lat_func;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merge_buf;
    logic        req_unsupported;
    logic        req_misalign;

    // Replace the lanes selected by the store width and low address bits;
    // everything not selected keeps the value read from the cache.
    function automatic logic [31:0] merge_word(
        input logic [31:0] base,
        input logic [2:0]  f,
        input logic [1:0]  lane,
        input logic [31:0] data
    );
        logic [31:0] w;
        w = base;
        case (f)
            FUNC_SB: begin
                case (lane)
                    2'd0:    w[7:0]   = data[7:0];
                    2'd1:    w[15:8]  = data[7:0];
                    2'd2:    w[23:16] = data[7:0];
                    default: w[31:24] = data[7:0];
                endcase
            end
            FUNC_SH: begin
                if (lane[1]) begin
                    w[31:16] = data[15:0];
                end else begin
                    w[15:0] = data[15:0];
                end
            end
            default: w = data;
        endcase
        return w;
    endfunction

    assign req_unsupported = (func != FUNC_SB) && (func != FUNC_SH) && (func != FUNC_SW);

`ifdef MISALIGN_TRAP_EN
    logic lat_misalign;

    assign req_misalign = ((func == FUNC_SH) && addr[0]) ||
                          ((func == FUNC_SW) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_misalign <= 1'b0;
        end else if ((state == IDLE) && st_req) begin
            lat_misalign <= req_misalign;
        end
    end

    assign misalign_err = (state == DONE) && lat_misalign;
`else
    assign req_misalign = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // State, request latch and merge buffer. A word store preloads the merge
    // buffer with its data since it never passes through READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lat_func  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            merge_buf <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && st_req) begin
                lat_func  <= func;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                merge_buf <= wdata;
            end else if ((state == READ) && !mem_busy) begin
                merge_buf <= merge_word(mem_rdata, lat_func, lat_addr[1:0], lat_wdata);
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                busy = st_req;
                if (st_req) begin
                    if (req_unsupported || req_misalign) begin
                        state_next = DONE;
                    end else if (func == FUNC_SW) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = {lat_addr[31:2], 2'b00};
                if (!mem_busy) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = merge_buf;
                if (!mem_busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// -----------------------------------------------------------------------------
// tb_store_merge_unit
//
// Self-checking bench for store_merge_unit. Each store is expanded by a
// transaction-level model into the expected per-cycle timeline of outputs
// (request cycle, optional read phase, optional write phase, done pulse,
// idle cycle), including cache stall cycles. The DUT is then stepped through
// that timeline and every cycle is compared. Covers directed scenarios,
// reset behaviour and randomized stores. Honours MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_store_merge_unit;

    logic        clk;
    logic        reset;
    logic        st_req;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        misalign_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int txn_id = 0;
    int cyc_id = 0;

    typedef struct {
        logic        is_req;
        logic        st_req;
        logic        mem_busy;
        logic [31:0] rdata;
        logic        busy;
        logic        done;
        logic        rd;
        logic        wr;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        err;
    } cyc_t;

    store_merge_unit dut (
        .clk          (clk),
        .reset        (reset),
        .st_req       (st_req),
        .func         (func),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_busy     (mem_busy),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (txn %0d cyc %0d): got %h expected %h", tag, txn_id, cyc_id, obs, exp);
        end
    endtask

    // Build the expected cycle timeline of one store from the architectural
    // rules, then drive it and compare every cycle.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int rstall, input int wstall);
        cyc_t        tl[$];
        cyc_t        c;
        logic        unsupported;
        logic        mis;
        logic        need_read;
        logic        need_write;
        logic [31:0] exp_word;
        logic [31:0] word_addr;
        int          sh;

        unsupported = (f > 3'b010);
`ifdef MISALIGN_TRAP_EN
        mis = ((f == 3'b001) && a[0]) || ((f == 3'b010) && (a[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        need_write = !unsupported && !mis;
        need_read  = need_write && (f != 3'b010);
        word_addr  = a & ~32'h3;

        if (f == 3'b000) begin
            sh       = 8 * int'(a[1:0]);
            exp_word = (rd & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else if (f == 3'b001) begin
            sh       = 16 * int'(a[1]);
            exp_word = (rd & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end else begin
            exp_word = wd;
        end

        c = '{is_req: 1'b1, st_req: 1'b1, mem_busy: 1'b0, rdata: $urandom, busy: 1'b1,
              done: 1'b0, rd: 1'b0, wr: 1'b0, maddr: 32'h0, mwdata: 32'h0, err: 1'b0};
        tl.push_back(c);

        if (need_read) begin
            for (int i = 0; i <= rstall; i++) begin
                c = '{is_req: 1'b0, st_req: 1'($urandom), mem_busy: (i < rstall),
                      rdata: (i < rstall) ? $urandom : rd, busy: 1'b1, done: 1'b0,
                      rd: 1'b1, wr: 1'b0, maddr: word_addr, mwdata: 32'h0, err: 1'b0};
                tl.push_back(c);
            end
        end
        if (need_write) begin
            for (int i = 0; i <= wstall; i++) begin
                c = '{is_req: 1'b0, st_req: 1'($urandom), mem_busy: (i < wstall),
                      rdata: $urandom, busy: 1'b1, done: 1'b0,
                      rd: 1'b0, wr: 1'b1, maddr: word_addr, mwdata: exp_word, err: 1'b0};
                tl.push_back(c);
            end
        end

        c = '{is_req: 1'b0, st_req: 1'($urandom), mem_busy: 1'($urandom), rdata: $urandom,
              busy: 1'b0, done: 1'b1, rd: 1'b0, wr: 1'b0, maddr: 32'h0, mwdata: 32'h0, err: mis};
        tl.push_back(c);

        c = '{is_req: 1'b0, st_req: 1'b0, mem_busy: 1'($urandom), rdata: $urandom,
              busy: 1'b0, done: 1'b0, rd: 1'b0, wr: 1'b0, maddr: 32'h0, mwdata: 32'h0, err: 1'b0};
        tl.push_back(c);

        txn_id++;
        foreach (tl[i]) begin
            cyc_id = i + 1;
            @(negedge clk);
            st_req    = tl[i].st_req;
            mem_busy  = tl[i].mem_busy;
            mem_rdata = tl[i].rdata;
            if (tl[i].is_req) begin
                func  = f;
                addr  = a;
                wdata = wd;
            end else begin
                func  = 3'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
            #1;
            checkOutput("busy", 32'(busy), 32'(tl[i].busy));
            checkOutput("done", 32'(done), 32'(tl[i].done));
            checkOutput("mem_read", 32'(mem_read), 32'(tl[i].rd));
            checkOutput("mem_write", 32'(mem_write), 32'(tl[i].wr));
            checkOutput("misalign_err", 32'(misalign_err), 32'(tl[i].err));
            if (tl[i].rd || tl[i].wr) begin
                checkOutput("mem_addr", mem_addr, tl[i].maddr);
            end
            if (tl[i].wr) begin
                checkOutput("mem_wdata", mem_wdata, tl[i].mwdata);
            end
        end
    endtask

    // Outputs required in IDLE right after a reset edge with st_req low.
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'h0);
        checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, "_misalign_err"}, 32'(misalign_err), 32'h0);
    endtask

    initial begin
        int          r;
        logic [2:0]  f;

        reset     = 1'b1;
        st_req    = 1'b0;
        func      = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_busy  = 1'b0;

        // Reset wins over a simultaneous word-store request.
        @(negedge clk);
        @(negedge clk);
        st_req = 1'b1;
        func   = 3'b010;
        addr   = 32'h0000_0040;
        wdata  = 32'h1234_5678;
        @(negedge clk);
        reset  = 1'b0;
        st_req = 1'b0;
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        #1;
        checkIdleOutputs("reset_hold");

        $display("[TB] directed stores");
        applyStimulus(3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344, 0, 0);
        applyStimulus(3'b001, 32'h0000_0012, 32'hFFFF_BEEF, 32'h1122_3344, 0, 0);
        applyStimulus(3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0, 0);
        applyStimulus(3'b000, 32'h0000_0201, 32'h0000_0077, 32'hA5A5_A5A5, 3, 2);
        applyStimulus(3'b000, 32'h0000_0303, 32'h0000_00C3, 32'h0102_0304, 0, 0);
        applyStimulus(3'b001, 32'h0000_0410, 32'h0000_9876, 32'hCAFE_F00D, 1, 1);
        applyStimulus(3'b010, 32'h0000_0006, 32'hCAFE_BABE, 32'h0, 0, 0);
        applyStimulus(3'b001, 32'h0000_0013, 32'h0000_4321, 32'h5555_AAAA, 0, 0);
        applyStimulus(3'b111, 32'h0000_0050, 32'h1111_1111, 32'h0, 0, 0);

        // Reset in the middle of the write phase aborts the store.
        $display("[TB] reset during WRITE");
        txn_id++;
        cyc_id = 1;
        @(negedge clk);
        st_req    = 1'b1;
        func      = 3'b000;
        addr      = 32'h0000_0103;
        wdata     = 32'h0000_0055;
        mem_busy  = 1'b0;
        #1;
        checkOutput("abort_req_busy", 32'(busy), 32'h1);
        cyc_id = 2;
        @(negedge clk);
        st_req    = 1'b0;
        mem_rdata = 32'hAABB_CCDD;
        #1;
        checkOutput("abort_read", 32'(mem_read), 32'h1);
        cyc_id = 3;
        @(negedge clk);
        mem_busy = 1'b1;
        reset    = 1'b1;
        #1;
        checkOutput("abort_write", 32'(mem_write), 32'h1);
        checkOutput("abort_wdata", mem_wdata, 32'h55BB_CCDD);
        cyc_id = 4;
        @(negedge clk);
        reset    = 1'b0;
        mem_busy = 1'b0;
        #1;
        checkIdleOutputs("abort_idle");
        cyc_id = 5;
        @(negedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done), 32'h0);
        applyStimulus(3'b011, 32'h0000_0060, 32'h2222_2222, 32'h0, 0, 0);

        $display("[TB] randomized stores");
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                f = 3'b000;
            end else if (r < 6) begin
                f = 3'b001;
            end else if (r < 8) begin
                f = 3'b010;
            end else begin
                f = 3'($urandom_range(3, 7));
            end
            applyStimulus(f, $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
